instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 instr_fetch_clk  input  1  sole clock; all state on rising edge.
REQ-003 instr_fetch_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_fetch_mem_req  output  1  fetch request to instruction memory.
REQ-005 instr_fetch_mem_addr  output  32  word-aligned fetch address.
REQ-006 instr_fetch_mem_ack  input  1  instruction memory returns mem_rdata this cycle.
REQ-007 instr_fetch_mem_rdata  input  32  fetched instruction word.
REQ-008 instr_fetch_redirect  input  1  taken branch/jump; load new PC.
REQ-009 instr_fetch_redirect_pc  input  32  redirect target.
REQ-010 instr_fetch_stall  input  1  downstream cannot accept another instruction.
REQ-011 instr_fetch_instr  output  32  latched instruction; drives imm_gen_in.
REQ-012 instr_fetch_instr_type  output  4  type code; drives imm_gen_instr_type.
REQ-013 instr_fetch_instr_wr_en  output  1  one-cycle strobe; drives imm_gen_instr_wr_en.
REQ-014 instr_fetch_pc  output  32  address of instr_fetch_instr.
REQ-015 instr_fetch_err  output  1  sticky misaligned-redirect flag.

Function
REQ-016 FSM states: IDLE, REQ, VALID, HOLD; IDLE after reset.
REQ-017 IDLE: mem_req=0; next state REQ.
REQ-018 REQ: mem_req=1, mem_addr=fetch PC; held until mem_ack.
REQ-019 REQ with mem_ack and no redirect: latch mem_rdata into instr, decoded code into instr_type, fetch PC into pc; fetch PC += 4; next state VALID.
REQ-020 VALID: instr_wr_en=1 for exactly this cycle; mem_req=0; next HOLD if stall, else REQ.
REQ-021 HOLD: mem_req=0, wr_en=0; stays while stall; REQ when stall=0.
REQ-022 instr, instr_type, pc stable from VALID until the next accepted mem_ack.
REQ-023 Type decode on mem_rdata[6:0]: 0110011->0001, 0010011->0010, 0000011->0011, 1100111->0100, 1110011->0101, 0100011->0110, 1100011->0111, 0110111->1000, 0010111->1001, 1101111->1010, else->0000.
REQ-024 Redirect has priority in every state: fetch PC <= redirect_pc with bits [1:0] forced to 0, next state IDLE, wr_en=0 next cycle.
REQ-025 Redirect coinciding with mem_ack: rdata discarded; instr/instr_type/pc unchanged.
REQ-026 Redirect in VALID: wr_en still 1 that cycle (instruction already delivered); redirect applied.
REQ-027 PC increment wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-028 Latency: wr_en asserts exactly one cycle after the accepted mem_ack; back-to-back fetch rate with mem_ack tied high and stall=0 is one instruction per 2 cycles.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, fetch PC=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr=0, instr_type=0000, wr_en=0, pc=0, err=0.
REQ-030 Reset mid-request abandons the transaction; a mem_ack during reset is ignored.

Configuration
REQ-031 Macro INSTR_FETCH_MISALIGN_ERR_EN defined: redirect with redirect_pc[1:0]!=0 sets err to 1 the next cycle, held until reset; redirect still applied with [1:0] cleared.
REQ-032 Macro undefined: err tied 0; misaligned targets silently aligned.

Verification
REQ-033 Reset release, RESET_PC=0, mem_ack high, rdata=32'h00500093 -> mem_addr 0 then 4; wr_en pulses; instr_type=0010, pc=0.
REQ-034 rdata=32'hFE000EE3 (B-type) with stall=1 in VALID -> instr_type=0111; state HOLD, mem_req=0 for 5 stall cycles; wr_en not repeated; fetch resumes at pc+4.
REQ-035 Redirect to 32'h0000_0100 on the same cycle as mem_ack -> rdata dropped, no wr_en, next request addr 32'h100.
REQ-036 Fetch PC 32'hFFFF_FFFC acked -> pc=32'hFFFF_FFFC, next mem_addr 32'h0000_0000.
REQ-037 Macro defined, redirect_pc=32'h0000_0102 -> mem_addr 32'h100, err=1 until rst_n low; macro undefined -> err stays 0.
REQ-038 rst_n low while in REQ with mem_ack high -> outputs at reset values immediately, no wr_en.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: request/address out, acknowledge/read-data back.
interface instr_fetch_if;
    logic        instr_fetch_mem_req;
    logic [31:0] instr_fetch_mem_addr;
    logic        instr_fetch_mem_ack;
    logic [31:0] instr_fetch_mem_rdata;

    modport master (
        output instr_fetch_mem_req,
        output instr_fetch_mem_addr,
        input  instr_fetch_mem_ack,
        input  instr_fetch_mem_rdata
    );

    modport slave (
        input  instr_fetch_mem_req,
        input  instr_fetch_mem_addr,
        output instr_fetch_mem_ack,
        output instr_fetch_mem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches words, decodes an immediate-type code, honours redirect/stall.
// Optional sticky misaligned-redirect flag enabled by defining INSTR_FETCH_MISALIGN_ERR_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 instr_fetch_clk,
    input  logic                 instr_fetch_rst_n,
    instr_fetch_if.master        mem,
    input  logic                 instr_fetch_redirect,
    input  logic [31:0]          instr_fetch_redirect_pc,
    input  logic                 instr_fetch_stall,
    output logic [31:0]          instr_fetch_instr,
    output logic [3:0]           instr_fetch_instr_type,
    output logic                 instr_fetch_instr_wr_en,
    output logic [31:0]          instr_fetch_pc,
    output logic                 instr_fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [3:0]  instr_type_reg, instr_type_next;
    logic [31:0] pc_reg, pc_next;

    function automatic logic [3:0] decode_type(input logic [6:0] opcode);
        case (opcode)
            7'b0110011: return 4'b0001;
            7'b0010011: return 4'b0010;
            7'b0000011: return 4'b0011;
            7'b1100111: return 4'b0100;
            7'b1110011: return 4'b0101;
            7'b0100011: return 4'b0110;
            7'b1100011: return 4'b0111;
            7'b0110111: return 4'b1000;
            7'b0010111: return 4'b1001;
            7'b1101111: return 4'b1010;
            default:    return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge instr_fetch_clk or negedge instr_fetch_rst_n) begin
        if (!instr_fetch_rst_n) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            instr_reg      <= 32'h0;
            instr_type_reg <= 4'h0;
            pc_reg         <= 32'h0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            instr_reg      <= instr_next;
            instr_type_reg <= instr_type_next;
            pc_reg         <= pc_next;
        end
    end

    // Redirect overrides every state; a coinciding ack is dropped with the old path.
    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        instr_next      = instr_reg;
        instr_type_next = instr_type_reg;
        pc_next         = pc_reg;
        if (instr_fetch_redirect) begin
            fetch_pc_next = instr_fetch_redirect_pc & 32'hFFFF_FFFC;
            state_next    = IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = REQ;
                REQ: begin
                    if (mem.instr_fetch_mem_ack) begin
                        instr_next      = mem.instr_fetch_mem_rdata;
                        instr_type_next = decode_type(mem.instr_fetch_mem_rdata[6:0]);
                        pc_next         = fetch_pc_reg;
                        fetch_pc_next   = fetch_pc_reg + 32'd4;
                        state_next      = VALID;
                    end
                end
                VALID: state_next = instr_fetch_stall ? HOLD : REQ;
                HOLD: begin
                    if (!instr_fetch_stall) begin
                        state_next = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign mem.instr_fetch_mem_req  = (state_reg == REQ);
    assign mem.instr_fetch_mem_addr = fetch_pc_reg;
    assign instr_fetch_instr        = instr_reg;
    assign instr_fetch_instr_type   = instr_type_reg;
    assign instr_fetch_instr_wr_en  = (state_reg == VALID);
    assign instr_fetch_pc           = pc_reg;

`ifdef INSTR_FETCH_MISALIGN_ERR_EN
    logic err_reg, err_next;

    assign err_next = err_reg |
                      (instr_fetch_redirect & (instr_fetch_redirect_pc[1:0] != 2'b00));

    always_ff @(posedge instr_fetch_clk or negedge instr_fetch_rst_n) begin
        if (!instr_fetch_rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign instr_fetch_err = err_reg;
`else
    assign instr_fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised self-checking bench for instr_fetch against a cycle-level expectation model.
module tb_instr_fetch;

`ifdef INSTR_FETCH_MISALIGN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instr;
    logic [3:0]  instr_type;
    logic        instr_wr_en;
    logic [31:0] pc;
    logic        err;

    instr_fetch_if mem_bus ();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .instr_fetch_clk         (clk),
        .instr_fetch_rst_n       (rst_n),
        .mem                     (mem_bus),
        .instr_fetch_redirect    (redirect),
        .instr_fetch_redirect_pc (redirect_pc),
        .instr_fetch_stall       (stall),
        .instr_fetch_instr       (instr),
        .instr_fetch_instr_type  (instr_type),
        .instr_fetch_instr_wr_en (instr_wr_en),
        .instr_fetch_pc          (pc),
        .instr_fetch_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int fail_cnt = 0;

    // Opcode -> type code table, searched linearly by the reference decoder.
    logic [6:0] op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    logic [3:0] code_tab [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};

    // Expected observable behaviour for the current cycle.
    logic [31:0] m_fetch;
    logic        m_req, m_wr, m_gap, m_parked, m_err;
    logic [31:0] m_instr, m_pc;
    logic [3:0]  m_type;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_type(input logic [6:0] opcode);
        logic [3:0] code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (op_tab[i] == opcode) code = code_tab[i];
        end
        return code;
    endfunction

    task automatic model_reset();
        m_fetch  = RESET_PC;
        m_req    = 1'b0;
        m_wr     = 1'b0;
        m_gap    = 1'b1;
        m_parked = 1'b0;
        m_err    = 1'b0;
        m_instr  = 32'h0;
        m_type   = 4'h0;
        m_pc     = 32'h0;
    endtask

    // Rules in priority order: redirect, one idle cycle before requesting,
    // request until acked, deliver one cycle, then wait out any stall.
    task automatic model_step(input logic a, input logic [31:0] rd, input logic r,
                              input logic [31:0] rpc, input logic s);
        logic n_req = 1'b0;
        logic n_wr  = 1'b0;
        if (r) begin
            m_fetch  = {rpc[31:2], 2'b00};
            m_gap    = 1'b1;
            m_parked = 1'b0;
            if (ERR_EN && rpc[1:0] != 2'b00) m_err = 1'b1;
        end else if (m_gap) begin
            m_gap = 1'b0;
            n_req = 1'b1;
        end else if (m_req) begin
            if (a) begin
                m_instr = rd;
                m_type  = ref_type(rd[6:0]);
                m_pc    = m_fetch;
                m_fetch = m_fetch + 32'd4;
                n_wr    = 1'b1;
            end else begin
                n_req = 1'b1;
            end
        end else if (m_wr || m_parked) begin
            m_parked = s;
            n_req    = !s;
        end
        m_req = n_req;
        m_wr  = n_wr;
    endtask

    task automatic check_outputs();
        check_val("mem_req",    {31'b0, mem_bus.instr_fetch_mem_req}, {31'b0, m_req});
        check_val("mem_addr",   mem_bus.instr_fetch_mem_addr, m_fetch);
        check_val("wr_en",      {31'b0, instr_wr_en}, {31'b0, m_wr});
        check_val("instr",      instr, m_instr);
        check_val("instr_type", {28'b0, instr_type}, {28'b0, m_type});
        check_val("pc",         pc, m_pc);
        check_val("err",        {31'b0, err}, {31'b0, m_err});
        if (m_wr) $display("deliver pc=%08h instr=%08h type=%0d", m_pc, m_instr, m_type);
    endtask

    task automatic do_cycle(input logic a, input logic [31:0] rd, input logic r,
                            input logic [31:0] rpc, input logic s);
        check_outputs();
        mem_bus.instr_fetch_mem_ack   = a;
        mem_bus.instr_fetch_mem_rdata = rd;
        redirect    = r;
        redirect_pc = rpc;
        stall       = s;
        model_step(a, rd, r, rpc, s);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  sel;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        mem_bus.instr_fetch_mem_ack   = 1'b0;
        mem_bus.instr_fetch_mem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // First fetch after reset with ack tied high.
        repeat (3) do_cycle(1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
        // Branch word delivered into a 5+ cycle stall, then resume.
        repeat (8) do_cycle(1'b1, 32'hFE00_0EE3, 1'b0, 32'h0, 1'b1);
        repeat (4) do_cycle(1'b1, 32'h0000_0033, 1'b0, 32'h0, 1'b0);

        // Redirect on the same cycle as an ack drops the word.
        do_cycle(1'b0, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_cycle(1'b1, 32'h0000_006F, 1'b1, 32'h0000_0100, 1'b0);
        repeat (3) do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) do_cycle(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);

        // Fetch address wrap at the top of memory.
        do_cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        repeat (5) do_cycle(1'b1, 32'h0000_0017, 1'b0, 32'h0, 1'b0);

        // Misaligned redirect target.
        do_cycle(1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0);
        repeat (4) do_cycle(1'b1, 32'h0000_0067, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset while requesting with ack high.
        do_cycle(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_outputs();
        mem_bus.instr_fetch_mem_ack   = 1'b1;
        mem_bus.instr_fetch_mem_rdata = 32'h0000_0073;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            sel = 4'($urandom_range(0, 10));
            rd  = $urandom();
            if (sel < 4'd10) rd[6:0] = op_tab[sel];
            do_cycle(($urandom_range(0, 9) < 6),
                     rd,
                     ($urandom_range(0, 15) == 0),
                     $urandom(),
                     ($urandom_range(0, 9) < 3));
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
